// File: rtl/fetch_pc_gen_pkg.sv
// Shared types for the fetch stage: queue entry layout and sequencer states.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned MAX_ADDR_W  = 64;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] pc;
        logic [31:0]           instr;
        logic                  pred_taken;
        logic [MAX_ADDR_W-1:0] pred_target;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: FIFO of predicted fetch entries with a single-cycle flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  fetch_entry_t       push_entry_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [CNT_W-1:0]   count_o,
    output logic               valid_o,
    output fetch_entry_t       head_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    // Entry fields read as zero while empty so decode never sees stale data.
    assign head_o  = valid_o ? mem_q[rd_q] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_entry_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC sequencer: one outstanding imem fetch, predicted next PC, redirect squash.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 64,
    parameter int unsigned        FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] pred_req_addr,
    input  logic [ADDR_W-1:0] pred_target,
    input  logic              pred_hit,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fq_out_valid,
    input  logic              fq_out_ready,
    output logic [ADDR_W-1:0] fq_out_pc,
    output logic [31:0]       fq_out_instr,
    output logic              fq_out_pred_taken,
    output logic [ADDR_W-1:0] fq_out_pred_target
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_target_q;
    logic              infl_taken_q;
    logic [ADDR_W-1:0] pc_plus4;
    logic              pred_taken;
    logic              req_hs;
    logic              push, flush;
    logic [CNT_W-1:0]  fq_count;
    fetch_entry_t      push_entry, head;

    assign pc_plus4       = pc_q + ADDR_W'(INSTR_BYTES);
    assign pred_taken     = pred_hit && (pred_target != pc_plus4);
    assign pred_req_addr  = pc_q;
    assign imem_req_addr  = pc_q;
    assign imem_req_valid = !reset && (state_q == S_REQ) && (fq_count < CNT_W'(FQ_DEPTH));
    assign req_hs         = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_REQ: begin
                if (req_hs) begin
                    state_d = S_WAIT;
                    pc_d    = {pred_target[ADDR_W-1:2], 2'b00};
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    push    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        // Redirect wins: an accepted request becomes a squashed one still owed a response.
        if (redirect_valid) begin
            flush = 1'b1;
            push  = 1'b0;
            pc_d  = {redirect_pc[ADDR_W-1:2], 2'b00};
            if (state_q == S_REQ) state_d = req_hs ? S_DROP : S_REQ;
            else                  state_d = imem_resp_valid ? S_REQ : S_DROP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= {RESET_PC[ADDR_W-1:2], 2'b00};
            infl_pc_q     <= '0;
            infl_target_q <= '0;
            infl_taken_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (req_hs) begin
                infl_pc_q     <= pc_q;
                infl_target_q <= pred_target;
                infl_taken_q  <= pred_taken;
            end
        end
    end

    always_comb begin
        push_entry             = '0;
        push_entry.pc          = MAX_ADDR_W'(infl_pc_q);
        push_entry.instr       = imem_resp_data;
        push_entry.pred_taken  = infl_taken_q;
        push_entry.pred_target = MAX_ADDR_W'(infl_target_q);
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk_i        (clk),
        .rst_i        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (fq_out_ready && !redirect_valid),
        .flush_i      (flush),
        .count_o      (fq_count),
        .valid_o      (fq_out_valid),
        .head_o       (head)
    );

    assign fq_out_pc          = head.pc[ADDR_W-1:0];
    assign fq_out_instr       = head.instr;
    assign fq_out_pred_taken  = head.pred_taken;
    assign fq_out_pred_target = head.pred_target[ADDR_W-1:0];

endmodule
